// File: rtl/generic_1clk_fifo_param.sv
// generic_1clk_fifo_param
// Single-clock FIFO over a register array. Depth may be any value >= 2 and
// need not be a power of two. Pointers wrap by compare, and occupancy is kept
// in a separate counter. Status flags are registered and follow the
// occupancy value produced by the same clock edge.
// Optional feature macro: GENERIC_1CLK_FIFO_FWFT_EN selects a
// first-word-fall-through read port. By default the read port is registered
// with a latency of one cycle.
module generic_1clk_fifo_param #(
  parameter int PTR_WIDTH      = 3,
  parameter int NUM_OF_ENTRIES = 6,
  parameter int DAT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 flush,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic                 rd_op,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 afull,
  output logic                 aempty,
  input  logic [PTR_WIDTH:0]   afull_thr,
  input  logic [PTR_WIDTH:0]   aempty_thr,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic                 full_err,
  output logic                 empty_err,
  input  logic                 err_clr
);

  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
  localparam logic [PTR_WIDTH:0]   MAX_CNT  = (PTR_WIDTH + 1)'(NUM_OF_ENTRIES);

  // Reject configurations whose pointers cannot address every entry.
  generate
    if (NUM_OF_ENTRIES < 2 || NUM_OF_ENTRIES > (1 << PTR_WIDTH)) begin : g_bad_cfg
      $error("generic_1clk_fifo_param: need 2 <= NUM_OF_ENTRIES <= 2**PTR_WIDTH");
    end
  endgenerate

  logic [DAT_WIDTH-1:0] mem [NUM_OF_ENTRIES];

  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_WIDTH:0]   cnt_nxt;
  logic                 wr_acc, rd_acc, full_err_set, empty_err_set;

  // Accept/reject decisions and next pointer and occupancy values.
  // When the FIFO is full, a write paired with a read is accepted because
  // the read frees the slot in the same edge. Flush suppresses every
  // operation and every error in its cycle.
  always_comb begin
    rd_acc        = rd_op & ~empty & ~flush;
    wr_acc        = wr_op & (~full | rd_op) & ~flush;
    full_err_set  = wr_op & full & ~rd_op & ~flush;
    empty_err_set = rd_op & empty & ~flush;

    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = entry_used;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_nxt = entry_used + 1'b1;
        2'b01:   cnt_nxt = entry_used - 1'b1;
        default: cnt_nxt = entry_used;
      endcase
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      entry_used <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      afull      <= (afull_thr == '0);
      aempty     <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      entry_used <= cnt_nxt;
      full       <= (cnt_nxt == MAX_CNT);
      empty      <= (cnt_nxt == '0);
      afull      <= (cnt_nxt >= afull_thr);
      aempty     <= (cnt_nxt <= aempty_thr);
    end
  end

  // Storage is not reset, but a write is never committed while in reset.
  always_ff @(posedge clk) begin
    if (!sreset && wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Sticky errors. A new error in the same cycle takes priority over a clear.
  always_ff @(posedge clk) begin
    if (sreset) begin
      full_err  <= 1'b0;
      empty_err <= 1'b0;
    end else begin
      if (full_err_set)       full_err <= 1'b1;
      else if (err_clr)       full_err <= 1'b0;
      if (empty_err_set)      empty_err <= 1'b1;
      else if (err_clr)       empty_err <= 1'b0;
    end
  end

`ifdef GENERIC_1CLK_FIFO_FWFT_EN
  // The head word is presented directly, and rd_op only acknowledges the pop.
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  // Registered read port: the word appears one cycle after the pop and is
  // held until the next accepted read.
  always_ff @(posedge clk) begin
    if (sreset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_generic_1clk_fifo_param.sv
// Directed bench for generic_1clk_fifo_param in its default registered-read
// build (DAT_WIDTH=8, NUM_OF_ENTRIES=6, PTR_WIDTH=3).
module tb_generic_1clk_fifo_param;

  logic       clk = 1'b0;
  logic       sreset, flush, wr_op, rd_op, err_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, afull, aempty, full_err, empty_err;
  logic [3:0] afull_thr, aempty_thr, entry_used;

  always #5 clk = ~clk;

  generic_1clk_fifo_param #(.PTR_WIDTH(3), .NUM_OF_ENTRIES(6), .DAT_WIDTH(8)) dut (
    .clk(clk), .sreset(sreset), .flush(flush), .wr_op(wr_op), .wr_data(wr_data),
    .rd_op(rd_op), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .afull(afull), .aempty(aempty), .afull_thr(afull_thr),
    .aempty_thr(aempty_thr), .entry_used(entry_used), .full_err(full_err),
    .empty_err(empty_err), .err_clr(err_clr)
  );

  typedef struct {
    logic       s, f, w, r, c;
    logic [7:0] wd;
    logic [3:0] aft, aet;
    logic [3:0] eu;
    logic       fu, em, af, ae, rv;
    logic [7:0] rd;
    logic       fe, ee;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] cur_aft = 4'd5, cur_aet = 4'd1;
  int checks = 0, errors = 0;

  task automatic add(input logic s, f, w, input logic [7:0] wd, input logic r, c,
                     input logic [3:0] eu, input logic fu, em, af, ae, rv,
                     input logic [7:0] rd, input logic fe, ee);
    vec_t v;
    v.s = s; v.f = f; v.w = w; v.wd = wd; v.r = r; v.c = c;
    v.aft = cur_aft; v.aet = cur_aet;
    v.eu = eu; v.fu = fu; v.em = em; v.af = af; v.ae = ae; v.rv = rv;
    v.rd = rd; v.fe = fe; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic s, f, w, input logic [7:0] wd, input logic r, c);
    sreset = s; flush = f; wr_op = w; wr_data = wd; rd_op = r; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t2_rd [6];
    t2_rd[0] = 8'h22; t2_rd[1] = 8'h33; t2_rd[2] = 8'h44;
    t2_rd[3] = 8'h55; t2_rd[4] = 8'h66; t2_rd[5] = 8'h88;

    sreset = 1'b1; flush = 1'b0; wr_op = 1'b0; rd_op = 1'b0; err_clr = 1'b0;
    wr_data = '0; afull_thr = 4'd5; aempty_thr = 4'd1;

    // ---- table: s f w wd r c | eu fu em af ae rv rd fe ee
    add(1,0,0,8'h00,0,0, 0,0,1,0,1,0,8'h00,0,0);
    // 1: fill 0x11..0x66, drain in order
    for (int k = 1; k <= 6; k++)
      add(0,0,1,8'(8'h11*k),0,0, 4'(k), k==6, 0, k>=5, k<=1, 0, 8'h00, 0,0);
    for (int k = 1; k <= 6; k++)
      add(0,0,0,8'h00,1,0, 4'(6-k), 0, k==6, (6-k)>=5, (6-k)<=1, 1, 8'(8'h11*k), 0,0);
    add(0,0,0,8'h00,0,0, 0,0,1,0,1,0,8'h66,0,0);
    // 2: fill, wr+rd while full, rejected 0x77, drain, clear
    for (int k = 1; k <= 6; k++)
      add(0,0,1,8'(8'h11*k),0,0, 4'(k), k==6, 0, k>=5, k<=1, 0, 8'h66, 0,0);
    add(0,0,1,8'h88,1,0, 6,1,0,1,0,1,8'h11,0,0);
    add(0,0,1,8'h77,0,0, 6,1,0,1,0,0,8'h11,1,0);
    for (int k = 1; k <= 6; k++)
      add(0,0,0,8'h00,1,0, 4'(6-k), 0, k==6, (6-k)>=5, (6-k)<=1, 1, t2_rd[k-1], 1,0);
    add(0,0,0,8'h00,0,1, 0,0,1,0,1,0,8'h88,0,0);
    // 4: underflow, wr+rd on empty, clear racing a new error
    add(0,0,0,8'h00,1,0, 0,0,1,0,1,0,8'h88,0,1);
    add(0,0,1,8'h99,1,0, 1,0,0,0,1,0,8'h88,0,1);
    add(0,0,0,8'h00,1,0, 0,0,1,0,1,1,8'h99,0,1);
    add(0,0,0,8'h00,1,1, 0,0,1,0,1,0,8'h99,0,1);
    add(0,0,0,8'h00,0,1, 0,0,1,0,1,0,8'h99,0,0);
    // 5: occupancy 4, threshold extremes, flush, then reset with error set
    for (int k = 1; k <= 4; k++)
      add(0,0,1,8'(8'hA0+k),0,0, 4'(k), 0,0,0, k<=1, 0, 8'h99, 0,0);
    cur_aft = 4'd0; cur_aet = 4'd6;
    add(0,0,0,8'h00,0,0, 4,0,0,1,1,0,8'h99,0,0);
    cur_aft = 4'd5; cur_aet = 4'd1;
    add(0,0,0,8'h00,0,0, 4,0,0,0,0,0,8'h99,0,0);
    add(0,1,1,8'hBB,1,0, 0,0,1,0,1,0,8'h99,0,0);
    add(0,1,0,8'h00,1,0, 0,0,1,0,1,0,8'h99,0,0);
    add(0,0,1,8'hDD,0,0, 1,0,0,0,1,0,8'h99,0,0);
    add(0,0,0,8'h00,1,0, 0,0,1,0,1,1,8'hDD,0,0);
    add(0,0,0,8'h00,1,0, 0,0,1,0,1,0,8'hDD,0,1);
    add(1,0,1,8'hCC,1,0, 0,0,1,0,1,0,8'h00,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      afull_thr = tbl[i].aft; aempty_thr = tbl[i].aet;
      step(tbl[i].s, tbl[i].f, tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].c);
      chk("entry_used", i, 32'(entry_used), 32'(tbl[i].eu));
      chk("full",       i, 32'(full),       32'(tbl[i].fu));
      chk("empty",      i, 32'(empty),      32'(tbl[i].em));
      chk("afull",      i, 32'(afull),      32'(tbl[i].af));
      chk("aempty",     i, 32'(aempty),     32'(tbl[i].ae));
      chk("rd_valid",   i, 32'(rd_valid),   32'(tbl[i].rv));
      chk("rd_data",    i, 32'(rd_data),    32'(tbl[i].rd));
      chk("full_err",   i, 32'(full_err),   32'(tbl[i].fe));
      chk("empty_err",  i, 32'(empty_err),  32'(tbl[i].ee));
    end

    // 3: steady-state wr+rd at occupancy 3; pointers wrap three times
    afull_thr = 4'd5; aempty_thr = 4'd1;
    step(1,0,0,8'h00,0,0);
    for (int k = 0; k < 3; k++) step(0,0,1,8'(8'h20+k),0,0);
    chk("t3_fill", 0, 32'(entry_used), 32'd3);
    for (int i = 0; i < 20; i++) begin
      step(0,0,1,8'(8'h23+i),1,0);
      chk("t3_used",  i, 32'(entry_used), 32'd3);
      chk("t3_valid", i, 32'(rd_valid),   32'd1);
      chk("t3_data",  i, 32'(rd_data),    32'(8'h20+i));
    end
    for (int j = 0; j < 3; j++) begin
      step(0,0,0,8'h00,1,0);
      chk("t3_drain", j, 32'(rd_data), 32'(8'h34+j));
    end
    chk("t3_empty", 0, 32'(empty), 32'd1);
    chk("t3_errs",  0, 32'({full_err, empty_err}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
